// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage                                                     |
// | Desc     : rv32i fetch stage: PC, imem drive, fetch FIFO, redirect, fault. |
// |            Optional perf counters enabled by defining FETCH_PERF_EN.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 1024,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        fault,
   output logic [31:0] fault_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [32:0]      PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [31:0]      pc;
   logic [31:0]      pc_next;
   logic [31:0]      fault_pc_next;
   logic [31:0]      fifo_instr [FIFO_DEPTH];
   logic [31:0]      fifo_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;
   logic             push;
   logic             flush;
   logic             redirect_bad;
   logic             pc_out_of_range;

   assign imem_addr   = pc;
   assign id_valid    = (count != '0);
   assign pop         = id_valid & id_ready;
   assign id_instr    = fifo_instr[rd_ptr];
   assign id_pc       = fifo_pc[rd_ptr];
   assign id_pc_plus4 = id_pc + 32'd4;
   assign fault       = (state == ST_FAULT);

   assign redirect_bad    = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);
   assign pc_out_of_range = ({1'b0, pc} >= PC_LIMIT);

   // Redirect outranks run-off, which outranks a sequential push.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      fault_pc_next = fault_pc;
      push          = 1'b0;
      flush         = 1'b0;
      case (state)
         ST_RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (redirect_bad) begin
                  state_next    = ST_FAULT;
                  fault_pc_next = redirect_pc;
               end else begin
                  pc_next = redirect_pc;
               end
            end else if (pc_out_of_range) begin
               state_next    = ST_FAULT;
               fault_pc_next = pc;
            end else if ((count != CNT_FULL) || pop) begin
               push    = 1'b1;
               pc_next = pc + 32'd4;
            end
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         pc       <= RESET_PC;
         fault_pc <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         fault_pc <= fault_pc_next;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]    <= pc;
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (id_valid && !id_ready) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
